// File: rtl/st_seq_pkg.sv
// Shared types and constants for the MIX ST store sequencer.
// Holds the state encoding, word geometry and the field-legality check.
package st_seq_pkg;

    localparam int MIX_ADDR_W = 12;
    localparam int MIX_WORD_W = 31;
    localparam int BYTE_W     = 6;
    localparam int N_BYTES    = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_MERGE = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } st_state_t;

    // F = 8L+R is legal when L <= R <= 5; (0:0) selects the sign alone.
    function automatic logic field_legal(input logic [5:0] f);
        return (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
    endfunction

endpackage

// File: rtl/st_seq_merge.sv
// ST field-merge unit: replaces bytes L..R of a memory word with the low bytes of a register.
// Ports: clk, rst_n, i_start, i_data (memory word), i_in (register), i_field, o_stop, o_out.
module st_seq_merge
    import st_seq_pkg::*;
#(
    parameter int WORD_W = MIX_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_data,
    input  logic [WORD_W-1:0] i_in,
    input  logic [5:0]        i_field,
    output logic              o_stop,
    output logic [WORD_W-1:0] o_out
);

    logic r_stop;

    // Register bytes are right-aligned so the source for byte R is reg byte 5;
    // shifting left by (5-R) bytes lines every source byte up with its target.
    function automatic logic [WORD_W-1:0] merge_word(
        input logic [WORD_W-1:0] data,
        input logic [WORD_W-1:0] in,
        input logic [2:0]        l,
        input logic [2:0]        r
    );
        logic [WORD_W-1:0] res;
        logic [WORD_W-2:0] sh;
        res = data;
        sh  = in[WORD_W-2:0] << (BYTE_W * (N_BYTES - int'(r)));
        if (l == 3'd0) begin
            res[WORD_W-1] = in[WORD_W-1];
        end
        for (int k = 1; k <= N_BYTES; k++) begin
            if (k >= int'(l) && k <= int'(r)) begin
                res[BYTE_W*(N_BYTES-k) +: BYTE_W] = sh[BYTE_W*(N_BYTES-k) +: BYTE_W];
            end
        end
        return res;
    endfunction

    assign o_out  = merge_word(i_data, i_in, i_field[5:3], i_field[2:0]);
    assign o_stop = r_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop <= 1'b0;
        end else begin
            r_stop <= i_start;
        end
    end

endmodule

// File: rtl/st_seq.sv
// MIX ST store sequencer: read-modify-write of one memory word under a field spec.
// Ports: start/addr/reg_in/field request, busy/stop/err status, mem_* memory port.
module st_seq
    import st_seq_pkg::*;
#(
    parameter int ADDR_W = MIX_ADDR_W,
    parameter int WORD_W = MIX_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] reg_in,
    input  logic [5:0]        field,
    output logic              busy,
    output logic              stop,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata
);

    st_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_in;
    logic [5:0]        r_field;
    logic              r_illegal;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_wdata;
    logic              r_busy;
    logic              r_stop;
    logic              r_err;
    logic              r_re;
    logic              r_we;

    logic              w_mstart;
    logic              w_mstop;
    logic [WORD_W-1:0] w_mout;

    assign w_mstart = (r_state == S_LATCH);

    st_seq_merge #(
        .WORD_W (WORD_W)
    ) u_merge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mstart),
        .i_data  (r_word),
        .i_in    (r_in),
        .i_field (r_field),
        .o_stop  (w_mstop),
        .o_out   (w_mout)
    );

    assign busy      = r_busy;
    assign stop      = r_stop;
    assign err       = r_err;
    assign mem_addr  = r_addr;
    assign mem_re    = r_re;
    assign mem_we    = r_we;
    assign mem_wdata = r_wdata;

    // Strobes are set on the edge entering their state, so each output
    // is high exactly for the one cycle spent in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_in      <= '0;
            r_field   <= '0;
            r_illegal <= 1'b0;
            r_word    <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_stop    <= 1'b0;
            r_err     <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
        end else begin
            r_re   <= 1'b0;
            r_we   <= 1'b0;
            r_stop <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr  <= addr;
                        r_in    <= reg_in;
                        r_field <= field;
                        r_busy  <= 1'b1;
                        if (field_legal(field)) begin
                            r_illegal <= 1'b0;
                            r_re      <= 1'b1;
                            r_state   <= S_READ;
                        end else begin
                            r_illegal <= 1'b1;
                            r_stop    <= 1'b1;
                            r_err     <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_word  <= mem_rdata;
                    r_state <= S_MERGE;
                end
                S_MERGE: begin
                    if (w_mstop) begin
                        r_wdata <= w_mout;
                        r_we    <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_stop  <= 1'b1;
                    r_err   <= r_illegal;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/st_seq.md
ST_SEQ -- requirements
Module: st_seq

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (4000-word MIX store).
REQ-002 Parameter WORD_W, default 31, MIX word width: bit 30 sign, five 6-bit bytes (byte 1 = bits 29:24, byte 5 = bits 5:0).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle store request; sampled only in IDLE.
REQ-007 addr  in  ADDR_W  target memory address.
REQ-008 reg_in  in  WORD_W  source register word (rA/rX/rIi/rJ already sign-extended by caller).
REQ-009 field  in  6  field spec F = 8L+R; L = field[5:3], R = field[2:0].
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 stop  out  1  one-cycle completion pulse.
REQ-012 err  out  1  one-cycle pulse with stop when field is illegal.
REQ-013 mem_addr  out  ADDR_W  memory address, held for whole operation.
REQ-014 mem_re  out  1  read strobe; mem_rdata valid the cycle after.
REQ-015 mem_rdata  in  WORD_W  memory read data.
REQ-016 mem_we  out  1  write strobe.
REQ-017 mem_wdata  out  WORD_W  merged word to write.

Function
REQ-018 States: IDLE, READ, LATCH, MERGE, WRITE, DONE.
REQ-019 IDLE + start: latch addr, reg_in, field; legal field -> READ, illegal -> DONE with err flag set.
REQ-020 Field legal iff L <= R and R <= 5; (0:0) is legal and stores sign only.
REQ-021 READ (1 cycle): mem_re=1, mem_addr = latched addr.
REQ-022 LATCH (1 cycle): capture mem_rdata into word register; pulse merge-unit start with reg_in and field.
REQ-023 MERGE (1 cycle): merge unit stop is high; capture its out into mem_wdata register; word register held stable.
REQ-024 Merged word: bytes L..R (L=0 means sign plus bytes 1..R) replaced by the rightmost (R-L+1) bytes of reg_in (sign of reg_in when L=0); all other bits from memory.
REQ-025 WRITE (1 cycle): mem_we=1 with mem_addr and mem_wdata stable.
REQ-026 DONE (1 cycle): stop=1, err = latched illegal flag; -> IDLE.
REQ-027 Legal store latency: start at cycle 0 -> mem_re cycle 1, mem_we cycle 4, stop cycle 5; illegal: stop+err cycle 1, no mem_re/mem_we.
REQ-028 start while busy ignored; no queuing; new start accepted in IDLE the cycle after DONE.
REQ-029 mem_re and mem_we never both high; each asserted at most once per operation.

Reset
REQ-030 rst_n low forces IDLE immediately; busy, stop, err, mem_re, mem_we = 0; mem_addr, mem_wdata, latched registers = 0.
REQ-031 Reset during any state aborts the operation; no write issued after reset even if asserted in MERGE.

Structure
REQ-032 Shared package: state encoding, WORD_W, BYTE_W=6, ADDR_W, field-legality function.
REQ-033 One sub-module: the existing st field-merge unit, instantiated once; st_seq supplies data, in, field, start and samples out only while its stop is high.

Verification
REQ-034 mem[100] = +|1|2|3|4|5, reg_in = -|6|7|8|9|0, field 13 (1:5) -> mem_we cycle 4, mem[100] = +|6|7|8|9|0, stop cycle 5, err 0.
REQ-035 Same words, field 45 (5:5) -> mem[100] = +|1|2|3|4|0; field 0 (0:0) -> -|1|2|3|4|5; field 18 (2:2) -> +|1|0|3|4|5.
REQ-036 Field 26 (3:2) and field 6 (0:6) -> stop+err cycle 1, mem_re and mem_we never asserted, memory unchanged.
REQ-037 Second start pulsed in cycles 2 and 5 of a store -> both ignored; exactly one write, busy falls cycle 6.
REQ-038 rst_n low during MERGE -> all outputs 0 within same cycle, mem_we never asserted, memory unchanged; next start completes normally.
